// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: funct3 encodings, FSM states,
// and access-size helpers used by both the stage and the load aligner.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, ACCESS} mem_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;

  // Undefined encodings fall through to word size.
  function automatic mem_size_t size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (size_of(f3))
      SZ_B:    return 1'b1;
      SZ_H:    return ~a[0];
      default: return (a == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (size_of(f3))
      SZ_B:    return 4'b0001 << a;
      SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian lane selection and sign/zero extension of a loaded word.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues handshaked loads/stores, stalls upstream while
// an access is outstanding, and registers the MEM/WB writeback results.
module mem_stage
  import mem_pkg::*;
#(
  parameter int AW   = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            XM_valid,
  input  logic [4:0]      XM_rd,
  input  logic            XM_wer,
  input  logic [XLEN-1:0] XM_alu_out,
  input  logic [XLEN-1:0] XM_store_data,
  input  logic            XM_mem_read,
  input  logic            XM_mem_write,
  input  logic [2:0]      XM_funct3,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [AW-1:0]   dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [31:0]     dmem_wdata,
  input  logic            dmem_ack,
  input  logic [31:0]     dmem_rdata,
  output logic            stall_out,
  output logic            misalign_err,
  output logic [4:0]      MW_rd_out,
  output logic            MW_wer_out,
  output logic [XLEN-1:0] L_regdata_out
);

  mem_state_t      state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            mis_q, mis_d;
  logic [4:0]      rd_q, rd_d;
  logic            wer_q, wer_d;
  logic [XLEN-1:0] data_q, data_d;

  logic        is_mem;
  logic [1:0]  lane;
  logic [31:0] load_data;
  logic [31:0] store_lanes;

  assign is_mem = XM_mem_read | XM_mem_write;
  assign lane   = XM_alu_out[1:0];

  load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .addr_i   (lane),
    .funct3_i (XM_funct3),
    .data_o   (load_data)
  );

  always_comb begin
    case (size_of(XM_funct3))
      SZ_B:    store_lanes = {4{XM_store_data[7:0]}};
      SZ_H:    store_lanes = {2{XM_store_data[15:0]}};
      default: store_lanes = XM_store_data[31:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    mis_d     = 1'b0;
    rd_d      = rd_q;
    wer_d     = 1'b0;
    data_d    = data_q;
    stall_out = 1'b0;

    case (state_q)
      IDLE: begin
        if (XM_valid && is_mem) begin
          if (is_aligned(XM_funct3, lane)) begin
            stall_out = 1'b1;
            req_d     = 1'b1;
            // A load+store combination is illegal and resolves as a load.
            we_d      = XM_mem_write & ~XM_mem_read;
            addr_d    = {XM_alu_out[AW-1:2], 2'b00};
            be_d      = byte_en(XM_funct3, lane);
            wdata_d   = store_lanes;
            state_d   = ACCESS;
          end else begin
            mis_d = 1'b1;
          end
        end else if (XM_valid) begin
          rd_d   = XM_rd;
          data_d = XM_alu_out;
          wer_d  = XM_wer & (XM_rd != 5'd0);
        end
      end
      ACCESS: begin
        stall_out = ~dmem_ack;
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          rd_d    = XM_rd;
          if (XM_mem_read) begin
            wer_d  = XM_wer & (XM_rd != 5'd0);
            data_d = load_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rd_q    <= '0;
      wer_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      rd_q    <= rd_d;
      wer_q   <= wer_d;
      data_q  <= data_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign misalign_err  = mis_q;
  assign MW_rd_out     = rd_q;
  assign MW_wer_out    = wer_q;
  assign L_regdata_out = data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads/stores with varied
// wait states, misalignment, ack in IDLE and reset during an access.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        XM_valid;
  logic [4:0]  XM_rd;
  logic        XM_wer;
  logic [31:0] XM_alu_out;
  logic [31:0] XM_store_data;
  logic        XM_mem_read;
  logic        XM_mem_write;
  logic [2:0]  XM_funct3;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_out;
  logic        misalign_err;
  logic [4:0]  MW_rd_out;
  logic        MW_wer_out;
  logic [31:0] L_regdata_out;

  int checks = 0;
  int errors = 0;

  mem_stage #(.AW(32), .XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .XM_valid      (XM_valid),
    .XM_rd         (XM_rd),
    .XM_wer        (XM_wer),
    .XM_alu_out    (XM_alu_out),
    .XM_store_data (XM_store_data),
    .XM_mem_read   (XM_mem_read),
    .XM_mem_write  (XM_mem_write),
    .XM_funct3     (XM_funct3),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .stall_out     (stall_out),
    .misalign_err  (misalign_err),
    .MW_rd_out     (MW_rd_out),
    .MW_wer_out    (MW_wer_out),
    .L_regdata_out (L_regdata_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    XM_valid     = 1'b0;
    XM_mem_read  = 1'b0;
    XM_mem_write = 1'b0;
    dmem_ack     = 1'b0;
  endtask

  // Runs one aligned memory op with `waits` non-ack ACCESS cycles, then acks.
  task automatic do_mem(input string tag, input logic [4:0] rd, input logic wer,
                        input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input int waits, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic exp_we);
    int stalls;
    stalls        = 0;
    XM_valid      = 1'b1;
    XM_rd         = rd;
    XM_wer        = wer;
    XM_mem_read   = rd_en;
    XM_mem_write  = wr_en;
    XM_funct3     = f3;
    XM_alu_out    = addr;
    XM_store_data = sdata;
    #1;
    if (stall_out) stalls++;
    chk({tag, "_stall_idle"}, {31'd0, stall_out}, 32'd1);
    tick();
    chk({tag, "_req"},   {31'd0, dmem_req}, 32'd1);
    chk({tag, "_addr"},  dmem_addr, exp_addr);
    chk({tag, "_be"},    {28'd0, dmem_be}, {28'd0, exp_be});
    chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
    chk({tag, "_we"},    {31'd0, dmem_we}, {31'd0, exp_we});
    for (int i = 0; i < waits; i++) begin
      if (stall_out) stalls++;
      chk({tag, "_wer_stall"}, {31'd0, MW_wer_out}, 32'd0);
      chk({tag, "_addr_hold"}, dmem_addr, exp_addr);
      tick();
    end
    chk({tag, "_stall_cycles"}, stalls, waits + 1);
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    #1;
    chk({tag, "_stall_ack"}, {31'd0, stall_out}, 32'd0);
    tick();
    idle_inputs();
    chk({tag, "_req_drop"}, {31'd0, dmem_req}, 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    XM_rd         = 5'd0;
    XM_wer        = 1'b0;
    XM_alu_out    = 32'd0;
    XM_store_data = 32'd0;
    XM_funct3     = 3'd0;
    dmem_rdata    = 32'd0;
    idle_inputs();
    #3;
    chk("rst_req",   {31'd0, dmem_req}, 32'd0);
    chk("rst_wer",   {31'd0, MW_wer_out}, 32'd0);
    chk("rst_rd",    {27'd0, MW_rd_out}, 32'd0);
    chk("rst_data",  L_regdata_out, 32'd0);
    chk("rst_mis",   {31'd0, misalign_err}, 32'd0);
    chk("rst_be",    {28'd0, dmem_be}, 32'd0);
    #9 rst_n = 1'b1;
    tick();

    // ALU op
    XM_valid = 1'b1; XM_rd = 5'd5; XM_wer = 1'b1; XM_alu_out = 32'h1234; XM_funct3 = 3'b000;
    #1;
    chk("alu_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("alu_rd",   {27'd0, MW_rd_out}, 32'd5);
    chk("alu_wer",  {31'd0, MW_wer_out}, 32'd1);
    chk("alu_data", L_regdata_out, 32'h1234);
    XM_valid = 1'b0; XM_rd = 5'd6; XM_alu_out = 32'h9999;
    tick();
    chk("bubble_wer",  {31'd0, MW_wer_out}, 32'd0);
    chk("bubble_rd",   {27'd0, MW_rd_out}, 32'd5);
    chk("bubble_data", L_regdata_out, 32'h1234);

    do_mem("lb", 5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 3, 32'h80FFFFFF,
           32'h100, 4'b1000, 32'h0, 1'b0);
    chk("lb_data", L_regdata_out, 32'hFFFFFF80);
    chk("lb_wer",  {31'd0, MW_wer_out}, 32'd1);
    chk("lb_rd",   {27'd0, MW_rd_out}, 32'd7);

    do_mem("lhu", 5'd8, 1'b1, 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'hBEEF1234,
           32'h100, 4'b1100, 32'h0, 1'b0);
    chk("lhu_data", L_regdata_out, 32'h0000BEEF);

    do_mem("lh", 5'd8, 1'b1, 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'hBEEF1234,
           32'h100, 4'b1100, 32'h0, 1'b0);
    chk("lh_data", L_regdata_out, 32'hFFFFBEEF);

    do_mem("lbu", 5'd3, 1'b1, 1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 0, 32'h0000F000,
           32'h100, 4'b0010, 32'h0, 1'b0);
    chk("lbu_data", L_regdata_out, 32'h000000F0);

    do_mem("sb", 5'd9, 1'b1, 1'b0, 1'b1, 3'b000, 32'h201, 32'hAB, 2, 32'h0,
           32'h200, 4'b0010, 32'hABABABAB, 1'b1);
    chk("sb_wer",  {31'd0, MW_wer_out}, 32'd0);
    chk("sb_data", L_regdata_out, 32'h000000F0);

    do_mem("sh", 5'd9, 1'b1, 1'b0, 1'b1, 3'b001, 32'h202, 32'h1234CAFE, 0, 32'h0,
           32'h200, 4'b1100, 32'hCAFECAFE, 1'b1);
    chk("sh_wer", {31'd0, MW_wer_out}, 32'd0);

    do_mem("lw_rd0", 5'd0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1, 32'hDEADBEEF,
           32'h104, 4'b1111, 32'h0, 1'b0);
    chk("lw_rd0_wer",  {31'd0, MW_wer_out}, 32'd0);
    chk("lw_rd0_data", L_regdata_out, 32'hDEADBEEF);

    do_mem("rw_both", 5'd4, 1'b1, 1'b1, 1'b1, 3'b010, 32'h400, 32'h77777777, 0, 32'h11223344,
           32'h400, 4'b1111, 32'h77777777, 1'b0);
    chk("rw_both_data", L_regdata_out, 32'h11223344);
    chk("rw_both_wer",  {31'd0, MW_wer_out}, 32'd1);

    // Misaligned word load
    XM_valid = 1'b1; XM_rd = 5'd2; XM_wer = 1'b1; XM_mem_read = 1'b1;
    XM_funct3 = 3'b010; XM_alu_out = 32'h102;
    #1;
    chk("mis_stall", {31'd0, stall_out}, 32'd0);
    tick();
    idle_inputs();
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_wer", {31'd0, MW_wer_out}, 32'd0);
    tick();
    chk("mis_pulse_end", {31'd0, misalign_err}, 32'd0);

    // Ack in IDLE must be ignored
    dmem_ack = 1'b1; dmem_rdata = 32'hCCCCCCCC;
    tick();
    dmem_ack = 1'b0;
    chk("idle_ack_req",  {31'd0, dmem_req}, 32'd0);
    chk("idle_ack_data", L_regdata_out, 32'h11223344);
    chk("idle_ack_wer",  {31'd0, MW_wer_out}, 32'd0);

    // Reset during ACCESS, then a late ack
    XM_valid = 1'b1; XM_rd = 5'd10; XM_wer = 1'b1; XM_mem_read = 1'b1;
    XM_funct3 = 3'b010; XM_alu_out = 32'h300;
    tick();
    chk("rst_acc_req_before", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_acc_req",   {31'd0, dmem_req}, 32'd0);
    chk("rst_acc_data",  L_regdata_out, 32'd0);
    chk("rst_acc_stall", {31'd0, stall_out}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    dmem_ack = 1'b1; dmem_rdata = 32'h55555555;
    tick();
    dmem_ack = 1'b0;
    chk("late_ack_req",  {31'd0, dmem_req}, 32'd0);
    chk("late_ack_data", L_regdata_out, 32'd0);
    chk("late_ack_wer",  {31'd0, MW_wer_out}, 32'd0);
    chk("late_ack_rd",   {27'd0, MW_rd_out}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline. Sits between the EX/MEM pipeline register (XM_*) and WB_reg.
- Runs loads and stores against a handshaked data memory, then aligns and sign-extends load data.
- Registers the MEM/WB results MW_rd_out, MW_wer_out and L_regdata_out.
- Stalls upstream while a memory access is outstanding.

Parameters:
- AW, 32, data-memory byte-address width.
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- XM_valid  in  1  the XM stage holds a real instruction.
- XM_rd  in  5  destination register.
- XM_wer  in  1  the instruction writes rd.
- XM_alu_out  in  32  ALU result, or effective address for memory ops.
- XM_store_data  in  32  rs2 value for stores.
- XM_mem_read  in  1  instruction is a load.
- XM_mem_write  in  1  instruction is a store.
- XM_funct3  in  3  access size and sign.
- dmem_req  out  1  memory request, registered, held until ack.
- dmem_we  out  1  1 = store.
- dmem_addr  out  AW  word-aligned address; bits [1:0] are 0.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  store data, replicated into byte lanes.
- dmem_ack  in  1  single-cycle completion strobe.
- dmem_rdata  in  32  read word, valid when dmem_ack=1.
- stall_out  out  1  combinational; upstream holds XM and earlier stages while high.
- misalign_err  out  1  registered one-cycle pulse on a misaligned access.
- MW_rd_out  out  5  registered rd.
- MW_wer_out  out  1  registered write enable.
- L_regdata_out  out  32  registered writeback data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All registered outputs 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, misalign_err, MW_*, L_regdata_out.
  - If reset hits mid-ACCESS, the transaction is abandoned and dmem_req drops immediately. A late dmem_ack after reset is ignored.
- FSM states: IDLE, ACCESS.
- IDLE, XM_valid=0: next edge MW_wer_out<=0; MW_rd_out and L_regdata_out hold.
- IDLE, valid non-memory op: 1-cycle latency.
  - MW_rd_out<=XM_rd.
  - L_regdata_out<=XM_alu_out.
  - MW_wer_out<=XM_wer & (XM_rd!=0).
  - stall_out=0.
- IDLE, valid memory op, aligned:
  - stall_out=1 this cycle.
  - Next edge: dmem_req<=1, dmem_we<=XM_mem_write, dmem_addr<={addr[AW-1:2],2'b00}, plus be and wdata; state<=ACCESS; MW_wer_out<=0 (bubble).
- ACCESS:
  - dmem_req stays 1 with constant address, be and wdata.
  - stall_out=!dmem_ack.
  - Each non-ack cycle: MW_wer_out<=0.
  - On the ack edge:
    - dmem_req<=0; state<=IDLE.
    - MW_rd_out<=XM_rd.
    - Load: MW_wer_out<=XM_wer & (rd!=0); L_regdata_out<=aligned load data.
    - Store: MW_wer_out<=0.
  - Upstream advances on that same edge.
  - Minimum memory-op latency is 2 cycles (ack on the first ACCESS cycle).
- dmem_ack in IDLE is ignored.
- XM_mem_read and XM_mem_write both 1 is illegal; treat as a load.
- Alignment rule:
  - Halfword needs addr[0]=0; word needs addr[1:0]=0; bytes are always aligned.
  - Misaligned: no request, stall_out=0, next edge misalign_err<=1 for one cycle and MW_wer_out<=0.
- funct3 encodings: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
  - Undefined encodings behave as word.
- Loads, little-endian:
  - Byte lane = addr[1:0]; halfword = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Stores:
  - SB: be = 1<<addr[1:0]; wdata = byte replicated ×4.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = halfword ×2.
  - SW: be = 4'b1111.
- Loads drive be for the accessed bytes too.

Decomposition:
- Package mem_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - mem_state_t enum {IDLE, ACCESS}.
  - Function that computes byte enables.
- Sub-module load_align (combinational):
  - Inputs: rdata, addr[1:0], funct3.
  - Output: 32-bit extended data.
- FSM, store lane steering and output registers stay in mem_stage.

Test Plan:
- ALU op, XM_rd=5, XM_alu_out=0x1234 -> next cycle MW_rd_out=5, MW_wer_out=1, L_regdata_out=0x1234, stall_out never high.
- LB at addr 0x103, ack after 3 ACCESS cycles, rdata=0x80FF_FF_FF:
  - dmem_addr=0x100, dmem_be=4'b1000.
  - stall_out high for 4 cycles.
  - L_regdata_out=0xFFFFFF80 and MW_wer_out=1 after the ack edge.
  - MW_wer_out=0 during all stall cycles.
- LHU at 0x102, rdata=0xBEEF1234 -> L_regdata_out=0x0000BEEF. LH at the same address and data -> 0xFFFFBEEF.
- SB at 0x201, store_data=0xAB -> dmem_be=4'b0010, dmem_wdata=0xABABABAB, dmem_we=1; after ack MW_wer_out=0.
- LW at 0x102 -> dmem_req stays 0, misalign_err pulses 1 cycle, stall_out=0, MW_wer_out=0.
- Load with XM_rd=0 -> MW_wer_out=0 after ack.
- rst_n low during ACCESS -> dmem_req=0 immediately and state=IDLE. An ack arriving after reset release changes no output.
